// File: rtl/fir_mac_sequencer_pkg.sv
// Shared FIR sequencer types: signed sample type, sequencer state encoding,
// power-on coefficient bank and its lookup helper.
// Compile-time option used by the datapath: FIR_SEQ_SATURATE_EN.
package fir_mac_sequencer_pkg;

    localparam int SAMPLE_W      = 16;
    localparam int FIR_INIT_TAPS = 4;

    typedef logic signed [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    // Power-on coefficients for taps 0..3.
    localparam sample_t FIR_COEF_INIT [FIR_INIT_TAPS] = '{
        16'sd2, 16'sd3, -16'sd2, 16'sd8
    };

    // Reset value for tap idx; taps beyond the init table start at zero.
    function automatic sample_t fir_coef_init(input int idx);
        case (idx)
            0:       return FIR_COEF_INIT[0];
            1:       return FIR_COEF_INIT[1];
            2:       return FIR_COEF_INIT[2];
            3:       return FIR_COEF_INIT[3];
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_mac.sv
// Combinational multiply-accumulate step plus shift/narrow stage.
// Holds no state; the sequencer owns every register.
// FIR_SEQ_SATURATE_EN defined: shifted sum is clamped to the 16-bit range.
// Otherwise the low 16 bits are taken (two's-complement wrap).
module fir_mac_unit
    import fir_mac_sequencer_pkg::*;
#(
    parameter int AW    = 34,
    parameter int SHIFT = 0
) (
    input  logic signed [AW-1:0] acc,
    input  sample_t              coef,
    input  sample_t              sample,
    output logic signed [AW-1:0] acc_next,
    output sample_t              result
);

    localparam logic signed [AW-1:0] SAT_MAX = AW'(32767);
    localparam logic signed [AW-1:0] SAT_MIN = AW'(-32768);

    logic signed [31:0]   product;
    logic signed [AW-1:0] shifted;

    // One tap: full-precision product added into the wide accumulator, then
    // the running sum is scaled and narrowed so the final tap's value can be
    // registered straight into out_data.
    always_comb begin
        product  = 32'(coef) * 32'(sample);
        acc_next = acc + AW'(product);
        shifted  = acc_next >>> SHIFT;
`ifdef FIR_SEQ_SATURATE_EN
        if (shifted > SAT_MAX) begin
            result = 16'sh7fff;
        end else if (shifted < SAT_MIN) begin
            result = 16'sh8000;
        end else begin
            result = 16'(shifted);
        end
`else
        result = 16'(shifted);
`endif
    end

endmodule

// File: rtl/fir_mac_sequencer.sv
// FIR sequencer: accepts one signed sample per input handshake into an
// NTAPS-deep circular delay line, runs one MAC per cycle over all taps and
// returns the filtered sample on a valid/ready output. Owns the
// runtime-writable coefficient bank.
// Optional feature macro: FIR_SEQ_SATURATE_EN (output saturation, see
// fir_mac_unit).
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer holds valid and data stable until that edge;
// ready may be asserted independently of valid. in_ready is only high in IDLE
// with clear low, out_valid only in DONE, so the two transfers never overlap.
module fir_mac_sequencer
    import fir_mac_sequencer_pkg::*;
#(
    parameter int NTAPS = 4,
    parameter int SHIFT = 0
) (
    input  logic                       system1000,
    input  logic                       system1000_rstn,
    input  logic                       in_valid,
    input  sample_t                    in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output sample_t                    out_data,
    input  logic                       out_ready,
    input  logic                       clear,
    input  logic                       coef_we,
    input  logic [$clog2(NTAPS)-1:0]   coef_addr,
    input  sample_t                    coef_data,
    output logic                       busy,
    output logic [1:0]                 dbg_state
);

    localparam int PW = $clog2(NTAPS);
    // acc never overflows: NTAPS products of at most 2^30 magnitude.
    localparam int AW = 32 + PW;

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [PW-1:0] TAP_LAST = PW'(NTAPS - 1);

    seq_state_t           state;
    sample_t              dline [NTAPS];
    sample_t              coef_q [NTAPS];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        tap;
    logic [PW-1:0]        rd_idx;
    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] acc_next;
    sample_t              mac_result;
    logic                 coef_wr_en;

    // wr_ptr has already moved past the newest sample, so tap 0 reads
    // wr_ptr-1 and older taps walk backwards around the ring.
    assign rd_idx = wr_ptr - PTR_ONE - tap;

    // Coefficients only change while idle so a running sum never mixes banks.
    assign coef_wr_en = coef_we && !clear && (state == ST_IDLE);

    assign in_ready  = (state == ST_IDLE) && !clear;
    assign busy      = (state != ST_IDLE);
    assign dbg_state = state;

    fir_mac_unit #(
        .AW    (AW),
        .SHIFT (SHIFT)
    ) u_mac (
        .acc      (acc),
        .coef     (coef_q[tap]),
        .sample   (dline[rd_idx]),
        .acc_next (acc_next),
        .result   (mac_result)
    );

    // Coefficient bank: one register per tap, loaded with the init table on
    // reset and rewritten by the idle-only write strobe; clear leaves it alone.
    for (genvar g = 0; g < NTAPS; g++) begin : g_coef
        localparam logic [PW-1:0] IDX = PW'(g);
        always_ff @(posedge system1000) begin
            if (!system1000_rstn) begin
                coef_q[g] <= fir_coef_init(g);
            end else if (coef_wr_en && (coef_addr == IDX)) begin
                coef_q[g] <= coef_data;
            end
        end
    end

    // Sequencer FSM: capture sample, step the MAC across all taps, then hold
    // the registered result until the consumer takes it. Reset and clear both
    // zero the delay line and discard any partial sum.
    always_ff @(posedge system1000) begin
        if (!system1000_rstn || clear) begin
            state     <= ST_IDLE;
            dline     <= '{default: '0};
            wr_ptr    <= '0;
            tap       <= '0;
            acc       <= '0;
            out_valid <= 1'b0;
            if (!system1000_rstn) begin
                out_data <= '0;
            end
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        dline[wr_ptr] <= in_data;
                        wr_ptr        <= wr_ptr + PTR_ONE;
                        acc           <= '0;
                        tap           <= '0;
                        state         <= ST_MAC;
                    end
                end
                ST_MAC: begin
                    acc <= acc_next;
                    if (tap == TAP_LAST) begin
                        out_data  <= mac_result;
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        tap <= tap + PTR_ONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Bench for fir_mac_sequencer: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// sample-history reference model.
module tb_fir_mac_sequencer;

    localparam int NTAPS = 4;
    localparam int SHIFT = 0;
    localparam int PW    = $clog2(NTAPS);

    // ---------------- clock / reset ----------------
    logic system1000      = 1'b0;
    logic system1000_rstn = 1'b0;
    always #5 system1000 = ~system1000;

    logic          in_valid  = 1'b0;
    logic [15:0]   in_data   = '0;
    logic          in_ready;
    logic          out_valid;
    logic [15:0]   out_data;
    logic          out_ready = 1'b1;
    logic          clear     = 1'b0;
    logic          coef_we   = 1'b0;
    logic [PW-1:0] coef_addr = '0;
    logic [15:0]   coef_data = '0;
    logic          busy;
    logic [1:0]    dbg_state;

    fir_mac_sequencer #(
        .NTAPS (NTAPS),
        .SHIFT (SHIFT)
    ) dut (
        .system1000      (system1000),
        .system1000_rstn (system1000_rstn),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_data        (out_data),
        .out_ready       (out_ready),
        .clear           (clear),
        .coef_we         (coef_we),
        .coef_addr       (coef_addr),
        .coef_data       (coef_data),
        .busy            (busy),
        .dbg_state       (dbg_state)
    );

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    bit done_flag = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // History of accepted samples since the last clear (newest at back);
    // anything older than the history counts as zero.
    longint      hist[$];
    longint      coef_m[NTAPS] = '{2, 3, -2, 8};
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];
    int          lat_q[$];
    int          pending = 0;
    int          age = 0;
    int          cyc = 0;
    int          acc_cyc = 0;
    bit          prev_ov = 0;
    bit          model_on = 0;

    function automatic logic [15:0] model_result();
        longint sum = 0;
        longint s;
        for (int k = 0; k < NTAPS; k++) begin
            s = (k < hist.size()) ? hist[hist.size() - 1 - k] : 0;
            sum += coef_m[k] * s;
        end
        sum = sum >>> SHIFT;
`ifdef FIR_SEQ_SATURATE_EN
        if (sum > 32767) sum = 32767;
        else if (sum < -32768) sum = -32768;
`endif
        return sum[15:0];
    endfunction

    // Compare process: outputs are sampled mid-cycle, inputs seen here are
    // the ones the DUT sees on the next rising edge.
    always @(negedge system1000) begin
        bit exp_ov;
        bit in_fire;
        bit out_fire;
        cyc++;
        if (model_on) begin
            if (pending != 0) age++;
            exp_ov = (pending != 0) && (age >= NTAPS + 1);
            check("in_ready", 32'(in_ready), 32'((pending == 0) && !clear));
            check("busy", 32'(busy), 32'(pending != 0));
            check("out_valid", 32'(out_valid), 32'(exp_ov));
            check("no_overlap", 32'(in_ready && out_valid), 32'(0));
            if (exp_ov && exp_q.size() > 0) begin
                check("out_data", {16'h0, out_data}, {16'h0, exp_q[0]});
            end
            if (out_valid && !prev_ov) lat_q.push_back(cyc - acc_cyc);

            if (clear) begin
                hist.delete();
                exp_q.delete();
                pending = 0;
                age = 0;
            end else begin
                in_fire  = in_valid && (pending == 0);
                out_fire = out_ready && exp_ov;
                if (coef_we && pending == 0) coef_m[coef_addr] = longint'($signed(coef_data));
                if (in_fire) begin
                    hist.push_back(longint'($signed(in_data)));
                    if (hist.size() > NTAPS) void'(hist.pop_front());
                    exp_q.push_back(model_result());
                    pending = 1;
                    age = 0;
                    acc_cyc = cyc;
                end
                if (out_fire) begin
                    got_q.push_back(out_data);
                    if (exp_q.size() > 0) void'(exp_q.pop_front());
                    pending = 0;
                end
            end
        end
        prev_ov = out_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge system1000);
        #1;
    endtask

    task automatic send(input logic [15:0] d);
        int t = 0;
        bit ok = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!ok && t < 300) begin
            @(negedge system1000);
            if (in_ready) ok = 1;
            t++;
        end
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready never rose for data %0h", d);
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_got(input int n);
        int t = 0;
        while (got_q.size() < n && t < 300) begin
            @(negedge system1000);
            t++;
        end
        if (got_q.size() < n) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_got: got %0d outputs required %0d", got_q.size(), n);
        end
        tick();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic write_coef(input logic [PW-1:0] a, input logic [15:0] d);
        coef_we   = 1'b1;
        coef_addr = a;
        coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic check_got(input string name, input logic [15:0] exp[], input int n);
        check({name, "_count"}, 32'(got_q.size()), 32'(n));
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            check(name, {16'h0, got_q[i]}, {16'h0, exp[i]});
        end
    endtask

    task automatic finish_report();
        if (!done_flag) begin
            done_flag = 1;
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        finish_report();
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] e_imp[]  = '{16'd2, 16'd3, 16'hFFFE, 16'd8, 16'd0};
        logic [15:0] e_step[] = '{16'd2, 16'd5, 16'd3, 16'd11, 16'd11};
        logic [15:0] e_bp[]   = '{16'd2, 16'd9};
        logic [15:0] e_two[]  = '{16'd2};
        logic [15:0] e_five[] = '{16'd5};
        logic [15:0] e_sat[];
`ifdef FIR_SEQ_SATURATE_EN
        e_sat = '{16'h7FFF};
`else
        e_sat = '{16'hFFFE};
`endif

        repeat (3) tick();
        system1000_rstn = 1'b1;
        @(negedge system1000);
        check("reset_in_ready", 32'(in_ready), 32'(1));
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_out_data", {16'h0, out_data}, 32'(0));
        check("reset_busy", 32'(busy), 32'(0));
        tick();
        model_on = 1;

        // Impulse response and latency.
        got_q.delete();
        lat_q.delete();
        send(16'd1);
        repeat (4) send(16'd0);
        wait_got(5);
        check_got("impulse", e_imp, 5);
        check("latency", 32'(lat_q.size() > 0 ? lat_q[0] : -1), 32'(NTAPS + 1));

        // Step response.
        pulse_clear();
        got_q.delete();
        repeat (5) send(16'd1);
        wait_got(5);
        check_got("step", e_step, 5);

        // Full-scale input, saturated or wrapped.
        pulse_clear();
        got_q.delete();
        send(16'd32767);
        wait_got(1);
        check_got("saturation", e_sat, 1);

        // Backpressure: result held while a new sample waits.
        pulse_clear();
        got_q.delete();
        out_ready = 1'b0;
        send(16'd1);
        in_valid = 1'b1;
        in_data  = 16'd3;
        repeat (NTAPS + 1 + 10) tick();
        check("bp_no_output", 32'(got_q.size()), 32'(0));
        out_ready = 1'b1;
        send(16'd3);
        wait_got(2);
        check_got("backpressure", e_bp, 2);

        // Clear mid-MAC with a simultaneous sample offer.
        pulse_clear();
        got_q.delete();
        send(16'd7);
        repeat (2) tick();
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd100;
        tick();
        clear    = 1'b0;
        in_valid = 1'b0;
        repeat (NTAPS + 4) tick();
        check("clear_no_out", 32'(got_q.size()), 32'(0));
        send(16'd1);
        wait_got(1);
        check_got("after_clear", e_two, 1);

        // Coefficient write while idle takes effect.
        got_q.delete();
        write_coef('0, 16'd5);
        pulse_clear();
        send(16'd1);
        wait_got(1);
        check_got("coef_idle", e_five, 1);

        // Same write during MAC is ignored.
        write_coef('0, 16'd2);
        pulse_clear();
        got_q.delete();
        send(16'd1);
        write_coef('0, 16'd5);
        wait_got(1);
        check_got("coef_mac", e_two, 1);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 1) == 1);
            in_data   = 16'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            clear     = ($urandom_range(0, 59) == 0);
            coef_we   = ($urandom_range(0, 9) == 0);
            coef_addr = PW'($urandom_range(0, NTAPS - 1));
            coef_data = 16'($urandom);
            tick();
        end
        in_valid  = 1'b0;
        clear     = 1'b0;
        coef_we   = 1'b0;
        out_ready = 1'b1;
        repeat (3 * NTAPS) tick();
        check("drained", 32'(exp_q.size()), 32'(0));

        finish_report();
    end

endmodule
